// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM receive path.
//   - Slot encoding follows the 2-bit operand selector (00=A .. 11=D).
//   - Framing FSM state encoding (HUNT / LOCK).
//   - Default sample width and the modulo-4 slot advance helper.
package tdm_pkg;

    typedef logic [1:0] slot_t;

    localparam int DEFAULT_WIDTH = 8;

    localparam slot_t SLOT_A = 2'b00;
    localparam slot_t SLOT_B = 2'b01;
    localparam slot_t SLOT_C = 2'b10;
    localparam slot_t SLOT_D = 2'b11;

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    // Slot index advances modulo 4, so D wraps back to A.
    function automatic slot_t next_slot(input slot_t s);
        return slot_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame-sync tracker for the TDM receiver.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   in_valid, sync  sample qualifier and frame-start marker
//   slot            slot expected for the next accepted sample
//   locked          high while the tracker is in LOCK
//   sync_err        registered one-cycle pulse on a framing violation
//   capture_en      combinational: write din into shadow[capture_slot] this edge
//   capture_slot    shadow register selected for capture
//   frame_complete  combinational: this edge accepts slot D and publishes a frame
module tdm_sync_fsm
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  logic  sync,
    output slot_t slot,
    output logic  locked,
    output logic  sync_err,
    output logic  capture_en,
    output slot_t capture_slot,
    output logic  frame_complete
);

    logic [0:0] state;

    assign locked = (state == LOCK);

    // A sync sample always becomes the new slot A, whatever state we are in.
    // Without sync, slots B and C go to the shadow registers, while slot D
    // bypasses them and triggers the frame publish instead.
    always_comb begin
        capture_en     = 1'b0;
        capture_slot   = SLOT_A;
        frame_complete = 1'b0;
        if (in_valid) begin
            if (sync) begin
                capture_en   = 1'b1;
                capture_slot = SLOT_A;
            end else if (state == LOCK && slot == SLOT_D) begin
                frame_complete = 1'b1;
            end else if (state == LOCK && slot != SLOT_A) begin
                capture_en   = 1'b1;
                capture_slot = slot;
            end
        end
    end

    // Framing state machine. A sync seen mid-frame restarts the frame at
    // slot B while staying locked; a missing sync at a frame boundary drops
    // back to HUNT. Both cases pulse sync_err. Idle cycles hold everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            slot     <= SLOT_A;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (in_valid) begin
                if (state == HUNT) begin
                    if (sync) begin
                        state <= LOCK;
                        slot  <= SLOT_B;
                    end
                end else if (sync) begin
                    if (slot != SLOT_A) begin
                        sync_err <= 1'b1;
                    end
                    slot <= SLOT_B;
                end else if (slot == SLOT_A) begin
                    sync_err <= 1'b1;
                    state    <= HUNT;
                    slot     <= SLOT_A;
                end else begin
                    slot <= next_slot(slot);
                end
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: locks onto frame sync, gathers slots A..C in
// shadow registers and publishes all four channels together when slot D
// arrives, so y_a..y_d are never partially updated.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   in_valid         din/sync qualify this cycle
//   sync             current sample is slot A
//   din              sample data
//   y_a..y_d         channels of the last complete frame
//   frame_valid      one-cycle pulse when y_a..y_d were just updated
//   slot             slot expected for the next accepted sample
//   locked           framing FSM is in LOCK
//   sync_err         one-cycle pulse on a framing violation
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sync,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] y_a,
    output logic [WIDTH-1:0] y_b,
    output logic [WIDTH-1:0] y_c,
    output logic [WIDTH-1:0] y_d,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    logic             capture_en;
    slot_t            capture_slot;
    logic             frame_complete;
    logic [WIDTH-1:0] shadow_a;
    logic [WIDTH-1:0] shadow_b;
    logic [WIDTH-1:0] shadow_c;

    tdm_sync_fsm u_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .sync           (sync),
        .slot           (slot),
        .locked         (locked),
        .sync_err       (sync_err),
        .capture_en     (capture_en),
        .capture_slot   (capture_slot),
        .frame_complete (frame_complete)
    );

    // Slot-indexed capture into the shadow registers. Stale shadow contents
    // after an early sync are harmless: every slot is rewritten before the
    // next publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_a <= '0;
            shadow_b <= '0;
            shadow_c <= '0;
        end else if (capture_en) begin
            case (capture_slot)
                SLOT_A:  shadow_a <= din;
                SLOT_B:  shadow_b <= din;
                SLOT_C:  shadow_c <= din;
                default: ;
            endcase
        end
    end

    // Publish the full frame on the edge that accepts slot D; slot D comes
    // straight from din so the outputs update with no extra latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_a         <= '0;
            y_b         <= '0;
            y_c         <= '0;
            y_d         <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_complete;
            if (frame_complete) begin
                y_a <= shadow_a;
                y_b <= shadow_b;
                y_c <= shadow_c;
                y_d <= din;
            end
        end
    end

endmodule
